// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit add/subtract built around one 4-bit carry-lookahead stage, low nibble first.
// Optional saturation of overflowing results is enabled by defining NIBBLE_ADDER_SAT_EN.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             cin_q, cin_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;
    logic             negative_q, negative_d;

    logic [3:0]       nib_a, nib_b, nib_g, nib_p, nib_c, nib_sum;
    logic             nib_cout;
    logic [WIDTH-1:0] acc_next, final_val;
    logic             ovf_raw;

    // Single 4-bit carry-lookahead stage fed by the nibble selected by the counter
    always_comb begin
        nib_a = opa_q[{cnt_q, 2'b00} +: 4];
        nib_b = opb_q[{cnt_q, 2'b00} +: 4];
        nib_g = nib_a & nib_b;
        nib_p = nib_a ^ nib_b;
        nib_c[0] = cin_q;
        nib_c[1] = nib_g[0] | (nib_p[0] & nib_c[0]);
        nib_c[2] = nib_g[1] | (nib_p[1] & nib_g[0]) | (nib_p[1] & nib_p[0] & nib_c[0]);
        nib_c[3] = nib_g[2] | (nib_p[2] & nib_g[1]) | (nib_p[2] & nib_p[1] & nib_g[0])
                 | (nib_p[2] & nib_p[1] & nib_p[0] & nib_c[0]);
        nib_cout = nib_g[3] | (nib_p[3] & nib_g[2]) | (nib_p[3] & nib_p[2] & nib_g[1])
                 | (nib_p[3] & nib_p[2] & nib_p[1] & nib_g[0])
                 | (nib_p[3] & nib_p[2] & nib_p[1] & nib_p[0] & nib_c[0]);
        nib_sum  = nib_p ^ nib_c;
    end

    // On the last nibble nib_c[3] is the carry into the MSB
    always_comb begin
        acc_next = acc_q;
        acc_next[{cnt_q, 2'b00} +: 4] = nib_sum;
        ovf_raw   = nib_cout ^ nib_c[3];
        final_val = acc_next;
`ifdef NIBBLE_ADDER_SAT_EN
        if (ovf_raw) begin
            final_val = opa_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        cin_d      = cin_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        result_d   = result_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;
        zero_d     = zero_q;
        negative_d = negative_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    // Subtraction is a + ~b + 1, the +1 entering as the initial carry
                    opa_d   = a;
                    opb_d   = sub ? ~b : b;
                    cin_d   = sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d = acc_next;
                cin_d = nib_cout;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_NIB) begin
                    cnt_d      = '0;
                    state_d    = DONE;
                    result_d   = final_val;
                    carry_d    = nib_cout;
                    overflow_d = ovf_raw;
                    zero_d     = (final_val == '0);
                    negative_d = final_val[WIDTH-1];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            opa_q      <= '0;
            opb_q      <= '0;
            cin_q      <= 1'b0;
            cnt_q      <= '0;
            acc_q      <= '0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
            negative_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            cin_q      <= cin_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            result_q   <= result_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
            negative_q <= negative_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign result   = result_q;
    assign carry    = carry_q;
    assign overflow = overflow_q;
    assign zero     = zero_q;
    assign negative = negative_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed testbench for nibble_serial_adder (WIDTH=16); honours NIBBLE_ADDER_SAT_EN for expected values.
module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy, done, carry, overflow, zero, negative;
    logic [15:0] result;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic        vsub;
        logic [15:0] vres;
        logic        vc, vv, vz, vn;
    } vec_t;

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .carry(carry),
        .overflow(overflow), .zero(zero), .negative(negative)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Issue one operation and wait (bounded) for done; lat = edges from start edge to done, -1 on timeout
    task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic isub, output int lat);
        @(negedge clk);
        a = ia; b = ib; sub = isub; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #2;
        vectors++;
        if ({busy, done, carry, overflow, zero, negative} !== 6'b0 || result !== 16'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: actual busy=%b done=%b res=%h cvzn=%b%b%b%b required all 0",
                     busy, done, result, carry, overflow, zero, negative);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
    endtask

    task automatic test_vectors();
        vec_t vecs[11];
        int lat;
        vecs[0]  = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
`ifdef NIBBLE_ADDER_SAT_EN
        vecs[7]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{16'h8000, 16'h8000, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{16'h7000, 16'h9000, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0};
`else
        vecs[7]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{16'h7000, 16'h9000, 1'b1, 16'hE000, 1'b0, 1'b1, 1'b0, 1'b1};
`endif
        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vsub, lat);
            vectors++;
            if (lat !== 4) begin
                miscompares++;
                $display("[TB] FAIL latency[%0d]: actual=%0d required=4", i, lat);
            end
            vectors++;
            if (result !== vecs[i].vres) begin
                miscompares++;
                $display("[TB] FAIL result[%0d]: actual=%h required=%h", i, result, vecs[i].vres);
            end
            vectors++;
            if ({carry, overflow, zero, negative} !== {vecs[i].vc, vecs[i].vv, vecs[i].vz, vecs[i].vn}) begin
                miscompares++;
                $display("[TB] FAIL flags_cvzn[%0d]: actual=%b%b%b%b required=%b%b%b%b", i,
                         carry, overflow, zero, negative, vecs[i].vc, vecs[i].vv, vecs[i].vz, vecs[i].vn);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int  lat;
        bit  saw_done = 1'b0;
        run_op(16'hFFFF, 16'h0001, 1'b0, lat);
        vectors++;
        if (zero !== 1'b1 || carry !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL pre_reset_flags: actual z=%b c=%b required z=1 c=1", zero, carry);
        end
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({busy, done, carry, overflow, zero, negative} !== 6'b0 || result !== 16'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_run: actual busy=%b done=%b res=%h cvzn=%b%b%b%b required all 0",
                     busy, done, result, carry, overflow, zero, negative);
        end
        @(negedge clk) reset = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1'b1;
        end
        vectors++;
        if (saw_done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL abandoned_op: actual done/busy seen=1 required=0");
        end
    endtask

    task automatic test_ignore_start_in_run();
        int lat = -1;
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        a = 16'hFFFF; b = 16'h00FF; sub = 1'b1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int n = 2; n <= 20; n++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        vectors++;
        if (lat !== 4) begin
            miscompares++;
            $display("[TB] FAIL ignore_latency: actual=%0d required=4", lat);
        end
        vectors++;
        if (result !== 16'h5555) begin
            miscompares++;
            $display("[TB] FAIL ignore_result: actual=%h required=5555", result);
        end
        @(posedge clk); #1;
        vectors++;
        if ({busy, done} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL start_not_queued: actual busy=%b done=%b required 00", busy, done);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit gap = 1'b0;
        run_op(16'h1111, 16'h2222, 1'b0, lat);
        vectors++;
        if (result !== 16'h3333) begin
            miscompares++;
            $display("[TB] FAIL b2b_first: actual=%h required=3333", result);
        end
        a = 16'h0005; b = 16'h0005; sub = 1'b1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int n = 0; n < 3; n++) begin
            if (busy !== 1'b1) gap = 1'b1;
            @(posedge clk); #1;
        end
        if (busy !== 1'b1) gap = 1'b1;
        vectors++;
        if (gap !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL b2b_busy_gap: actual gap=1 required=0");
        end
        @(posedge clk); #1;
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL b2b_done: actual=%b required=1", done);
        end
        vectors++;
        if (result !== 16'h0000 || carry !== 1'b1 || zero !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL b2b_second: actual res=%h c=%b z=%b required 0000 1 1", result, carry, zero);
        end
        @(posedge clk); #1;
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL done_one_cycle: actual=%b required=0", done);
        end
    endtask

    initial begin
        $display("[TB] starting nibble_serial_adder bench");
        test_reset();
        test_vectors();
        test_reset_mid_run();
        test_ignore_start_in_run();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
